// File: rtl/accel_host_if.sv
// Host-side wrapper for an N x N matrix accelerator: holds operand and result banks,
// streams A/B operands as N*N beats, then captures the flattened result on acc_done.
module accel_host_if #(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    wr_sel,
  input  logic [$clog2(N*N)-1:0]  wr_addr,
  input  logic [W-1:0]            wr_data,
  input  logic                    go,
  input  logic [$clog2(N*N)-1:0]  rd_addr,
  output logic [W-1:0]            rd_data,
  output logic                    busy,
  output logic                    res_valid,
  output logic                    err,
  output logic                    acc_start,
  output logic                    acc_in_valid,
  output logic [W-1:0]            acc_a,
  output logic [W-1:0]            acc_b,
  input  logic                    acc_done,
  input  logic [N*N*W-1:0]        acc_result_flat
);

  localparam int AW = $clog2(N*N);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_BEAT = AW'(N*N - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    STREAM,
    WAIT,
    CAPTURE
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]  a_bank   [N*N];
  logic [W-1:0]  b_bank   [N*N];
  logic [W-1:0]  res_bank [N*N];
  logic [AW-1:0] beat;
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // acc_done before WAIT is a protocol violation and aborts the run.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = START;
      START:   state_nxt = acc_done ? IDLE : STREAM;
      STREAM: begin
        if (acc_done)                state_nxt = IDLE;
        else if (beat == LAST_BEAT)  state_nxt = WAIT;
      end
      WAIT: begin
        if (acc_done)               state_nxt = CAPTURE;
        else if (tcnt == TO_LAST)   state_nxt = IDLE;
      end
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    acc_start    = 1'b0;
    acc_in_valid = 1'b0;
    acc_a        = '0;
    acc_b        = '0;
    case (state)
      START:  acc_start = 1'b1;
      STREAM: begin
        acc_in_valid = 1'b1;
        acc_a        = a_bank[beat];
        acc_b        = b_bank[beat];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N*N; i++) begin
        a_bank[i]   <= '0;
        b_bank[i]   <= '0;
        res_bank[i] <= '0;
      end
      beat      <= '0;
      tcnt      <= '0;
      res_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en) begin
            if (wr_sel) b_bank[wr_addr] <= wr_data;
            else        a_bank[wr_addr] <= wr_data;
          end
          if (go) begin
            res_valid <= 1'b0;
            err       <= 1'b0;
            beat      <= '0;
            tcnt      <= '0;
          end
        end
        START: if (acc_done) err <= 1'b1;
        STREAM: begin
          if (acc_done) err  <= 1'b1;
          else          beat <= beat + 1'b1;
        end
        WAIT: begin
          if (!acc_done) begin
            if (tcnt == TO_LAST) err  <= 1'b1;
            else                 tcnt <= tcnt + 1'b1;
          end
        end
        CAPTURE: begin
          for (int unsigned i = 0; i < N*N; i++)
            res_bank[i] <= acc_result_flat[i*W +: W];
          res_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rd_data = res_bank[rd_addr];

endmodule

// File: tb/tb_accel_host_if.sv
// Directed self-checking bench for accel_host_if: per-cycle vector table for a full
// run plus hand-written sequences for timeout, early done, busy-time inputs and reset.
module tb_accel_host_if;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 64;
  localparam int NN = N*N;
  localparam int AW = $clog2(NN);

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic              wr_sel;
  logic [AW-1:0]     wr_addr;
  logic [W-1:0]      wr_data;
  logic              go;
  logic [AW-1:0]     rd_addr;
  logic [W-1:0]      rd_data;
  logic              busy;
  logic              res_valid;
  logic              err;
  logic              acc_start;
  logic              acc_in_valid;
  logic [W-1:0]      acc_a;
  logic [W-1:0]      acc_b;
  logic              acc_done;
  logic [NN*W-1:0]   acc_result_flat;

  accel_host_if #(.N(N), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .go(go), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .res_valid(res_valid), .err(err), .acc_start(acc_start),
    .acc_in_valid(acc_in_valid), .acc_a(acc_a), .acc_b(acc_b),
    .acc_done(acc_done), .acc_result_flat(acc_result_flat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         done;
    logic         busy;
    logic         start;
    logic         valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rv;
    logic         err;
  } vec_t;

  // Row i describes cycle i+1 after the go cycle of a normal run.
  vec_t tbl [22];
  int   checks = 0;
  int   errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_go();
    go = 1'b1;
    step();
    go = 1'b0;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 22; i++) begin
      acc_done = tbl[i].done;
      check($sformatf("%s c%0d busy", tag, i+1),      busy,         tbl[i].busy);
      check($sformatf("%s c%0d acc_start", tag, i+1), acc_start,    tbl[i].start);
      check($sformatf("%s c%0d in_valid", tag, i+1),  acc_in_valid, tbl[i].valid);
      check($sformatf("%s c%0d acc_a", tag, i+1),     acc_a,        tbl[i].a);
      check($sformatf("%s c%0d acc_b", tag, i+1),     acc_b,        tbl[i].b);
      check($sformatf("%s c%0d res_valid", tag, i+1), res_valid,    tbl[i].rv);
      check($sformatf("%s c%0d err", tag, i+1),       err,          tbl[i].err);
      step();
    end
    acc_done = 1'b0;
  endtask

  task automatic check_results(input string tag, input int mul, input int base);
    for (int i = 0; i < NN; i++) begin
      rd_addr = AW'(i);
      #1;
      check($sformatf("%s rd[%0d]", tag, i), rd_data, W'(base + mul*i));
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " busy"},      busy,         1'b0);
    check({tag, " res_valid"}, res_valid,    1'b0);
    check({tag, " err"},       err,          1'b0);
    check({tag, " acc_start"}, acc_start,    1'b0);
    check({tag, " in_valid"},  acc_in_valid, 1'b0);
    check({tag, " acc_a"},     acc_a,        '0);
    check({tag, " acc_b"},     acc_b,        '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts, beats, busy_bad;

    for (int i = 0; i < 22; i++)
      tbl[i] = '{done: 1'b0, busy: 1'b1, start: 1'b0, valid: 1'b0,
                 a: '0, b: '0, rv: 1'b0, err: 1'b0};
    tbl[0].start = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tbl[i].valid = 1'b1;
      tbl[i].a     = W'(i);
      tbl[i].b     = W'(2);
    end
    tbl[19].done = 1'b1;
    tbl[21].busy = 1'b0;
    tbl[21].rv   = 1'b1;

    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    go = 1'b0; rd_addr = '0; acc_done = 1'b0; acc_result_flat = '0;

    // Reset state
    step(); step();
    check_idle_zero("reset");
    rst = 1'b0;
    step();
    check_results("reset", 0, 0);

    // Load operands A[k]=k+1, B[k]=2
    for (int k = 0; k < NN; k++) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = AW'(k); wr_data = W'(k + 1);
      step();
      wr_sel = 1'b1; wr_data = W'(2);
      step();
    end
    wr_en = 1'b0;

    // Normal run, stub result word i = 3*i
    for (int i = 0; i < NN; i++) acc_result_flat[i*W +: W] = W'(3*i);
    pulse_go();
    run_table("run1");
    rd_addr = AW'(5);
    #1;
    check("run1 rd[5]", rd_data, 32'd15);
    check_results("run1", 3, 0);

    // Back-to-back run with different results; res_valid low until capture
    for (int i = 0; i < NN; i++) acc_result_flat[i*W +: W] = W'(100 + i);
    pulse_go();
    run_table("run2");
    check_results("run2", 1, 100);

    // Writes and go while busy are ignored
    starts = 0; beats = 0;
    pulse_go();
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (acc_start)    starts++;
      if (acc_in_valid) beats++;
      wr_en = (cyc == 5); wr_sel = 1'b0; wr_addr = '0; wr_data = 32'hFF;
      go = (cyc == 5);
      acc_done = (cyc == 19);
      step();
    end
    wr_en = 1'b0; go = 1'b0; acc_done = 1'b0;
    check("busy-ign start pulses", W'(starts), W'(1));
    check("busy-ign beats", W'(beats), W'(NN));
    check("busy-ign busy end", busy, 1'b0);
    check("busy-ign res_valid", res_valid, 1'b1);
    pulse_go();
    run_table("run3");

    // acc_done on beat 3 aborts the run with err
    pulse_go();
    for (int cyc = 1; cyc < 5; cyc++) step();
    check("early beat3 valid", acc_in_valid, 1'b1);
    check("early beat3 acc_a", acc_a, 32'd4);
    acc_done = 1'b1;
    step();
    acc_done = 1'b0;
    check("early in_valid", acc_in_valid, 1'b0);
    check("early busy", busy, 1'b0);
    check("early err", err, 1'b1);
    check("early acc_a", acc_a, '0);
    step(); step();
    check("early no beat", acc_in_valid, 1'b0);
    check("early err sticky", err, 1'b1);
    pulse_go();
    run_table("run4");

    // Timeout: WAIT entered at cycle 18; IDLE with err exactly TO cycles later
    pulse_go();
    for (int cyc = 1; cyc < 18; cyc++) step();
    busy_bad = 0;
    for (int k = 0; k < TO; k++) begin
      if (busy !== 1'b1 || acc_in_valid !== 1'b0 || err !== 1'b0) busy_bad++;
      step();
    end
    check("timeout wait cycles bad", W'(busy_bad), '0);
    check("timeout busy", busy, 1'b0);
    check("timeout err", err, 1'b1);
    check("timeout res_valid", res_valid, 1'b0);

    // Reset during beat 8 (cycle 10)
    pulse_go();
    for (int cyc = 1; cyc < 10; cyc++) step();
    check("rstmid beat8 acc_a", acc_a, 32'd9);
    rst = 1'b1;
    step();
    check_idle_zero("rstmid");
    check_results("rstmid", 0, 0);
    rst = 1'b0;
    starts = 0; beats = 0;
    for (int k = 0; k < 20; k++) begin
      if (acc_start || acc_in_valid || busy) starts++;
      step();
    end
    check("rstmid no activity", W'(starts), '0);
    check("rstmid res_valid", res_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/accel_host_if.md
ACCEL_HOST_IF -- requirements
Module: accel_host_if

Interface
- REQ-001: Parameter N, default 4, is the matrix dimension; it SHALL match the attached accelerator.
- REQ-002: Parameter W, default 32, is the operand and result word width.
- REQ-003: Parameter TIMEOUT, default 64, is the maximum number of cycles spent in WAIT.
- REQ-004: Port clk, input, 1, is the single clock; all logic SHALL be on its rising edge.
- REQ-005: Port rst, input, 1, is a synchronous active-high reset.
- REQ-006: Port wr_en, input, 1, is the host operand-write strobe.
- REQ-007: Port wr_sel, input, 1, selects the operand bank (0 = A bank, 1 = B bank).
- REQ-008: Port wr_addr, input, $clog2(N*N), is the operand word index.
- REQ-009: Port wr_data, input, W, is the operand word.
- REQ-010: Port go, input, 1, is the single-cycle run request.
- REQ-011: Port rd_addr, input, $clog2(N*N), is the result word index.
- REQ-012: Port rd_data, output, W, is the captured result word selected by rd_addr (combinational read).
- REQ-013: Port busy, output, 1, is high in every state except IDLE.
- REQ-014: Port res_valid, output, 1, indicates a captured result set is held.
- REQ-015: Port err, output, 1, is a sticky protocol/timeout error flag.
- REQ-016: Port acc_start, output, 1, is the accelerator start pulse.
- REQ-017: Port acc_in_valid, output, 1, is the accelerator input-beat valid.
- REQ-018: Port acc_a, output, W, is the accelerator A operand.
- REQ-019: Port acc_b, output, W, is the accelerator B operand.
- REQ-020: Port acc_done, input, 1, is the accelerator completion pulse.
- REQ-021: Port acc_result_flat, input, N*N*W, holds the accelerator results; word i occupies bits [i*W +: W].

Function
- REQ-022: The block SHALL hold two N*N x W operand banks, A and B, and one N*N x W result bank.
- REQ-023: In IDLE, wr_en SHALL write wr_data to bank[wr_sel][wr_addr] on the same edge; writes in any other state SHALL be ignored.
- REQ-024: The FSM states SHALL be IDLE, START, STREAM, WAIT, and CAPTURE.
- REQ-025: IDLE with go=1 SHALL move to START, clear res_valid and err, and clear the beat and timeout counters.
- REQ-026: go in any non-IDLE state SHALL be ignored.
- REQ-027: START SHALL drive acc_start=1 for exactly one cycle, then move to STREAM.
- REQ-028: STREAM SHALL drive acc_in_valid=1 for exactly N*N consecutive cycles; on beat k (0..N*N-1), acc_a SHALL equal A[k] and acc_b SHALL equal B[k]; after the last beat the FSM SHALL move to WAIT.
- REQ-029: Outside STREAM, acc_in_valid SHALL be 0 and acc_a/acc_b SHALL be 0; acc_start SHALL be 0 outside START.
- REQ-030: In WAIT, acc_done=1 SHALL move to CAPTURE; otherwise the timeout counter SHALL increment each cycle.
- REQ-031: When the timeout counter reaches TIMEOUT-1 without acc_done, the FSM SHALL set err=1 and return to IDLE with res_valid=0.
- REQ-032: acc_done=1 while in START or STREAM SHALL set err=1 and return the FSM to IDLE, aborting the run; no acc_in_valid beat SHALL follow.
- REQ-033: acc_done in IDLE or CAPTURE SHALL be ignored.
- REQ-034: CAPTURE SHALL copy all N*N words of acc_result_flat into the result bank in one cycle, set res_valid=1, and return to IDLE.
- REQ-035: Captured results SHALL remain stable until the next capture or reset.
- REQ-036: rd_data SHALL always return the result bank word at rd_addr, independent of state.
- REQ-037: Latency from go to the first acc_in_valid beat SHALL be 2 cycles; from acc_done to res_valid=1 SHALL be 2 cycles (CAPTURE plus register).

Reset
- REQ-038: While rst=1, the FSM SHALL be in IDLE and busy, res_valid, err, acc_start, acc_in_valid, acc_a, and acc_b SHALL all be 0.
- REQ-039: Reset SHALL clear all three banks to 0, so rd_data reads 0 after reset.
- REQ-040: Reset asserted mid-run SHALL abort the run immediately, with no further acc_start or acc_in_valid pulses, and no result capture.

Verification
- REQ-041: Scenario (normal run). Write A[k]=k+1 and B[k]=2; pulse go at cycle 0 -> acc_start=1 only at cycle 1; acc_in_valid=1 for cycles 2..17 with acc_a=1..16 and acc_b=2; the stub asserts acc_done with word i = 3*i -> res_valid=1 two cycles later, rd_addr=5 returns 15, busy=0.
- REQ-042: Scenario (timeout). Stub never asserts acc_done -> err=1 and busy=0 exactly TIMEOUT cycles after WAIT entry; res_valid=0.
- REQ-043: Scenario (early done). Pulse acc_done on beat 3 of STREAM -> acc_in_valid drops next cycle, err=1, FSM in IDLE; a following go clears err.
- REQ-044: Scenario (ignored inputs while busy). During STREAM, issue wr_en to A[0]=0xFF and a second go -> no extra beats or start pulse; a second run shows acc_a on beat 0 equals the original A[0].
- REQ-045: Scenario (reset mid-run). Assert rst during beat 8 -> all outputs are 0 the next cycle and rd_data=0 for every address.
- REQ-046: Scenario (back-to-back runs). Run twice with different stub results -> the second capture overwrites every word and res_valid is low between go and the second capture.
